// File: rtl/mul_arbiter.sv
// Round-robin front end that shares one iterative multiplier among NREQ requesters.
// One operation is in flight at a time; flush kills the owner's operation or pending result.
module mul_arbiter #(
    parameter int WID  = 80,
    parameter int NREQ = 4,
    parameter int TAGW = 6,
    localparam int IDW = $clog2(NREQ)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req,
    input  logic [NREQ-1:0]      sgn_i,
    input  logic [NREQ-1:0]      sgnus_i,
    input  logic [NREQ*WID-1:0]  a_i,
    input  logic [NREQ*WID-1:0]  b_i,
    input  logic [NREQ*TAGW-1:0] tag_i,
    output logic [NREQ-1:0]      ack,
    input  logic                 flush,
    input  logic [IDW-1:0]       flush_id,
    output logic                 mul_ld,
    output logic                 mul_abort,
    output logic                 mul_sgn,
    output logic                 mul_sgnus,
    output logic [WID-1:0]       mul_a,
    output logic [WID-1:0]       mul_b,
    input  logic [2*WID-1:0]     mul_o,
    input  logic                 mul_done,
    input  logic                 mul_idle,
    output logic                 res_valid,
    input  logic                 res_ready,
    output logic [IDW-1:0]       res_id,
    output logic [TAGW-1:0]      res_tag,
    output logic [2*WID-1:0]     res_o,
    output logic                 busy
);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

    state_t            r_state;
    state_t            w_next;
    logic [IDW-1:0]    r_rr;
    logic [IDW-1:0]    r_id;
    logic [WID-1:0]    r_a;
    logic [WID-1:0]    r_b;
    logic              r_sgn;
    logic              r_sgnus;
    logic [TAGW-1:0]   r_tag;
    logic              r_killed;
    logic [2*WID-1:0]  r_res;

    logic [IDW-1:0]    w_win;
    logic              w_any;
    int                w_idx;
    logic              w_grant;
    logic              w_flush_hit;
    logic              w_cmpl;
    logic              w_kill;

    // First requester above the last winner, wrapping around.
    always_comb begin
        w_win = '0;
        w_any = 1'b0;
        w_idx = 0;
        for (int k = 1; k <= NREQ; k++) begin
            w_idx = (int'(r_rr) + k) % NREQ;
            if (!w_any && req[w_idx]) begin
                w_any = 1'b1;
                w_win = IDW'(w_idx);
            end
        end
    end

    // rst gates the grant so ack stays low while reset is held.
    assign w_grant     = rst && (r_state == S_IDLE) && w_any && mul_idle;
    assign w_flush_hit = flush && (flush_id == r_id) && (r_state != S_IDLE);
    assign w_cmpl      = (r_state == S_WAIT) && mul_done && !mul_idle;
    assign w_kill      = r_killed || w_flush_hit;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (w_grant) w_next = S_ISSUE;
            S_ISSUE: w_next = S_WAIT;
            S_WAIT:  if (w_cmpl) w_next = w_kill ? S_IDLE : S_RESP;
            S_RESP:  if (w_flush_hit || res_ready) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        ack = '0;
        if (w_grant) ack[w_win] = 1'b1;
        mul_ld    = (r_state == S_ISSUE);
        mul_abort = (r_state == S_WAIT) && w_kill;
        res_valid = (r_state == S_RESP);
        busy      = (r_state != S_IDLE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rr     <= IDW'(NREQ - 1);
            r_id     <= '0;
            r_a      <= '0;
            r_b      <= '0;
            r_sgn    <= 1'b0;
            r_sgnus  <= 1'b0;
            r_tag    <= '0;
            r_killed <= 1'b0;
            r_res    <= '0;
        end else begin
            if (w_grant) begin
                r_a      <= a_i[w_win*WID +: WID];
                r_b      <= b_i[w_win*WID +: WID];
                r_sgn    <= sgn_i[w_win];
                r_sgnus  <= sgnus_i[w_win];
                r_tag    <= tag_i[w_win*TAGW +: TAGW];
                r_id     <= w_win;
                r_rr     <= w_win;
                r_killed <= 1'b0;
            end else if (w_flush_hit && (r_state == S_ISSUE || r_state == S_WAIT)) begin
                r_killed <= 1'b1;
            end
            if (w_cmpl && !w_kill) begin
                r_res <= mul_o;
            end
        end
    end

    assign mul_a     = r_a;
    assign mul_b     = r_b;
    assign mul_sgn   = r_sgn;
    assign mul_sgnus = r_sgnus;
    assign res_id    = r_id;
    assign res_tag   = r_tag;
    assign res_o     = r_res;

endmodule

// File: tb/tb_mul_arbiter.sv
// Directed bench for mul_arbiter with a small clocked multiplier model (ld -> done in 4 cycles).
module tb_mul_arbiter;
    localparam int WID  = 80;
    localparam int NREQ = 4;
    localparam int TAGW = 6;
    localparam int IDW  = $clog2(NREQ);
    localparam int PW   = 2 * WID;

    logic                 clk = 1'b0;
    logic                 rst;
    logic [NREQ-1:0]      req, sgn_i, sgnus_i, ack;
    logic [NREQ*WID-1:0]  a_i, b_i;
    logic [NREQ*TAGW-1:0] tag_i;
    logic                 flush;
    logic [IDW-1:0]       flush_id;
    logic                 mul_ld, mul_abort, mul_sgn, mul_sgnus;
    logic [WID-1:0]       mul_a, mul_b;
    logic [PW-1:0]        mul_o;
    logic                 mul_done, mul_idle;
    logic                 res_valid, res_ready;
    logic [IDW-1:0]       res_id;
    logic [TAGW-1:0]      res_tag;
    logic [PW-1:0]        res_o;
    logic                 busy;

    logic                 m_idle, m_done, hold;
    int                   m_cnt;
    logic [PW-1:0]        m_prod, m_ea, m_eb;
    int                   n_chk = 0;
    int                   n_err = 0;
    int                   n;
    int                   rr_exp [6] = '{0, 1, 2, 3, 0, 1};

    always #5 clk = ~clk;

    mul_arbiter #(.WID(WID), .NREQ(NREQ), .TAGW(TAGW)) dut (
        .clk(clk), .rst(rst), .req(req), .sgn_i(sgn_i), .sgnus_i(sgnus_i),
        .a_i(a_i), .b_i(b_i), .tag_i(tag_i), .ack(ack), .flush(flush), .flush_id(flush_id),
        .mul_ld(mul_ld), .mul_abort(mul_abort), .mul_sgn(mul_sgn), .mul_sgnus(mul_sgnus),
        .mul_a(mul_a), .mul_b(mul_b), .mul_o(mul_o), .mul_done(mul_done), .mul_idle(mul_idle),
        .res_valid(res_valid), .res_ready(res_ready), .res_id(res_id), .res_tag(res_tag),
        .res_o(res_o), .busy(busy)
    );

    // Multiplier model: sign-extend per mode, done one cycle early on abort.
    always_comb begin
        m_ea = (mul_sgn || mul_sgnus) ? {{WID{mul_a[WID-1]}}, mul_a} : {{WID{1'b0}}, mul_a};
        m_eb = mul_sgn ? {{WID{mul_b[WID-1]}}, mul_b} : {{WID{1'b0}}, mul_b};
    end

    assign mul_idle = m_idle & ~hold;
    assign mul_done = m_done;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_idle <= 1'b1; m_done <= 1'b0; m_cnt <= 0; mul_o <= '0; m_prod <= '0;
        end else if (m_done) begin
            m_done <= 1'b0; m_idle <= 1'b1;
        end else if (m_cnt != 0) begin
            if (mul_abort || m_cnt == 1) begin
                m_cnt <= 0; m_done <= 1'b1; mul_o <= m_prod;
            end else begin
                m_cnt <= m_cnt - 1;
            end
        end else if (mul_ld) begin
            m_prod <= m_ea * m_eb; m_idle <= 1'b0; m_cnt <= 3;
        end
    end

    task automatic chk(input string tag, input logic [PW-1:0] got, input logic [PW-1:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic set_op(input int id, input logic [WID-1:0] a, input logic [WID-1:0] b,
                          input logic s, input logic su, input logic [TAGW-1:0] t);
        a_i[id*WID +: WID]    = a;
        b_i[id*WID +: WID]    = b;
        tag_i[id*TAGW +: TAGW] = t;
        sgn_i[id]   = s;
        sgnus_i[id] = su;
    endtask

    task automatic wait_ack(input string tag, input int exp_id);
        int id;
        id = -1;
        for (int c = 0; c < 40; c++) begin
            #1;
            if (ack != '0) break;
            step;
        end
        chk({tag, "_seen"}, PW'(|ack), PW'(1));
        chk({tag, "_onehot"}, PW'($countones(ack)), PW'(1));
        for (int i = 0; i < NREQ; i++) if (ack[i]) id = i;
        chk({tag, "_id"}, PW'(id), PW'(exp_id));
    endtask

    task automatic wait_res(input string tag, output int cyc);
        cyc = 0;
        while (!res_valid && cyc < 40) begin
            step;
            #1;
            cyc++;
        end
        chk({tag, "_rv"}, PW'(res_valid), PW'(1));
    endtask

    task automatic wait_idle(input string tag);
        int c;
        c = 0;
        #1;
        while (busy && c < 60) begin
            step;
            c++;
        end
        chk({tag, "_idle"}, PW'(busy), PW'(0));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        rst = 1'b0; req = '1; sgn_i = '0; sgnus_i = '0; a_i = '0; b_i = '0; tag_i = '0;
        flush = 1'b0; flush_id = '0; res_ready = 1'b0; hold = 1'b0;
        #3;
        chk("rst_ack", PW'(ack), PW'(0));
        chk("rst_busy", PW'(busy), PW'(0));
        chk("rst_rv", PW'(res_valid), PW'(0));
        chk("rst_ld", PW'(mul_ld), PW'(0));
        chk("rst_abort", PW'(mul_abort), PW'(0));
        chk("rst_a", PW'(mul_a), PW'(0));
        chk("rst_res", res_o, PW'(0));
        chk("rst_id", PW'(res_id), PW'(0));
        step; step;
        rst = 1'b1; req = '0;

        // Unsigned 3*5, tag 0x2A, requester 0 first after reset.
        set_op(0, 80'd3, 80'd5, 1'b0, 1'b0, 6'h2A);
        req = 4'b0001;
        wait_ack("t1", 0);
        chk("t1_busy_g", PW'(busy), PW'(0));
        chk("t1_ld_g", PW'(mul_ld), PW'(0));
        step; req = '0; #1;
        chk("t1_ack_off", PW'(ack), PW'(0));
        chk("t1_ld", PW'(mul_ld), PW'(1));
        chk("t1_a", PW'(mul_a), PW'(3));
        chk("t1_b", PW'(mul_b), PW'(5));
        chk("t1_busy", PW'(busy), PW'(1));
        wait_res("t1", n);
        // ld cycle -> done 4 cycles later, result one cycle after done.
        chk("t1_lat", PW'(n), PW'(5));
        chk("t1_res", res_o, PW'(15));
        chk("t1_rid", PW'(res_id), PW'(0));
        chk("t1_tag", PW'(res_tag), PW'(6'h2A));
        res_ready = 1'b1; step; res_ready = 1'b0; #1;
        chk("t1_rv_off", PW'(res_valid), PW'(0));

        // Signed -7 * 6 on requester 2.
        set_op(2, -80'sd7, 80'd6, 1'b1, 1'b0, 6'h11);
        req = 4'b0100;
        wait_ack("t2", 2);
        step; req = '0;
        wait_res("t2", n);
        chk("t2_res", res_o, -160'sd42);
        chk("t2_rid", PW'(res_id), PW'(2));
        chk("t2_tag", PW'(res_tag), PW'(6'h11));
        res_ready = 1'b1; step; res_ready = 1'b0;

        // Signed -1 times unsigned (2^79 + 2) on requester 3.
        set_op(3, {WID{1'b1}}, 80'h8000_0000_0000_0000_0002, 1'b0, 1'b1, 6'h3F);
        req = 4'b1000;
        wait_ack("t3", 3);
        step; req = '0;
        wait_res("t3", n);
        chk("t3_res", res_o, 160'hFFFFFFFFFFFFFFFFFFFF_7FFFFFFFFFFFFFFFFFFE);
        res_ready = 1'b1; step; res_ready = 1'b0;

        // Round robin with all requesting.
        res_ready = 1'b1; req = 4'b1111;
        for (int k = 0; k < 6; k++) begin
            wait_ack($sformatf("rr%0d", k), rr_exp[k]);
            step;
        end
        req = 4'b1010;
        wait_ack("rr_skip", 3);
        step; req = '0;
        wait_idle("rr");

        // Backpressure with requester 1 pending.
        res_ready = 1'b0;
        set_op(0, 80'd7, 80'd9, 1'b0, 1'b0, 6'd1);
        req = 4'b0001;
        wait_ack("bp", 0);
        step;
        set_op(1, 80'd2, 80'd2, 1'b0, 1'b0, 6'd2);
        req = 4'b0010;
        wait_res("bp", n);
        chk("bp_res", res_o, PW'(63));
        for (int k = 0; k < 10; k++) begin
            step; #1;
            chk($sformatf("bp_rv%0d", k), PW'(res_valid), PW'(1));
            chk($sformatf("bp_res%0d", k), res_o, PW'(63));
            chk($sformatf("bp_ack%0d", k), PW'(ack), PW'(0));
        end
        res_ready = 1'b1; #1;
        chk("bp_acc_ack", PW'(ack), PW'(0));
        step; res_ready = 1'b0; #1;
        chk("bp_next_ack", PW'(ack), PW'(4'b0010));
        chk("bp_rv_off", PW'(res_valid), PW'(0));
        step; req = '0; res_ready = 1'b1;
        wait_idle("bp");

        // Flush of the owner during WAIT, requester 0 pending.
        set_op(2, 80'd4, 80'd4, 1'b0, 1'b0, 6'd3);
        req = 4'b0100;
        wait_ack("fw", 2);
        step; req = 4'b0001;
        step; flush = 1'b1; flush_id = 2'd2; #1;
        chk("fw_abort", PW'(mul_abort), PW'(1));
        step; flush = 1'b0; #1;
        chk("fw_abort_k", PW'(mul_abort), PW'(1));
        chk("fw_rv0", PW'(res_valid), PW'(0));
        step; #1;
        chk("fw_rv1", PW'(res_valid), PW'(0));
        chk("fw_busy", PW'(busy), PW'(0));
        chk("fw_next", PW'(ack), PW'(4'b0001));
        step; req = '0;
        wait_idle("fw");

        // Flush during RESP: non-owner ignored, owner drops the result.
        res_ready = 1'b0;
        set_op(1, 80'd6, 80'd7, 1'b0, 1'b0, 6'd4);
        req = 4'b0010;
        wait_ack("fr", 1);
        step; req = '0;
        wait_res("fr", n);
        chk("fr_res", res_o, PW'(42));
        flush = 1'b1; flush_id = 2'd3;
        step; flush = 1'b0; #1;
        chk("fr_other_rv", PW'(res_valid), PW'(1));
        chk("fr_other_res", res_o, PW'(42));
        flush = 1'b1; flush_id = 2'd1;
        step; flush = 1'b0; #1;
        chk("fr_rv_off", PW'(res_valid), PW'(0));
        chk("fr_busy", PW'(busy), PW'(0));

        // Flush in IDLE does not stop a same-cycle grant.
        res_ready = 1'b1;
        set_op(0, 80'd9, 80'd9, 1'b0, 1'b0, 6'd5);
        req = 4'b0001; flush = 1'b1; flush_id = 2'd0;
        wait_ack("fi", 0);
        step; flush = 1'b0; req = '0;
        wait_res("fi", n);
        chk("fi_res", res_o, PW'(81));
        chk("fi_tag", PW'(res_tag), PW'(5));
        wait_idle("fi");

        // No grant while the multiplier reports not idle.
        hold = 1'b1;
        set_op(2, 80'd3, 80'd3, 1'b0, 1'b0, 6'd6);
        req = 4'b0100; #1;
        chk("hold_ack0", PW'(ack), PW'(0));
        step; #1;
        chk("hold_ack1", PW'(ack), PW'(0));
        chk("hold_busy", PW'(busy), PW'(0));
        hold = 1'b0;
        wait_ack("hold", 2);
        step; req = '0;
        wait_idle("hold");

        // Asynchronous reset in WAIT.
        set_op(0, 80'd5, 80'd5, 1'b0, 1'b0, 6'd7);
        req = 4'b0001;
        wait_ack("rw", 0);
        step; req = '0;
        step; #1;
        chk("rw_a_pre", PW'(mul_a), PW'(5));
        chk("rw_busy_pre", PW'(busy), PW'(1));
        rst = 1'b0; #1;
        chk("rw_busy", PW'(busy), PW'(0));
        chk("rw_a", PW'(mul_a), PW'(0));
        chk("rw_tag", PW'(res_tag), PW'(0));
        chk("rw_rv", PW'(res_valid), PW'(0));
        req = 4'b1111;
        repeat (3) step;
        #1;
        chk("rw_ack_held", PW'(ack), PW'(0));
        chk("rw_rv_held", PW'(res_valid), PW'(0));
        step; rst = 1'b1;
        wait_ack("rw_after", 0);
        step; req = '0;
        wait_idle("end");

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule
